sevenseg_scan_ctrl: RTL and testbench
=====================================

// Module: sevenseg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a common-anode 7-segment display bank.
//  - Holds a double-buffered NUM_DIGITS-digit hex/BCD value.
//  - Cycles one digit per slot.
//  - Drives the 4-bit digit code plus dp into the downstream bcd_to_sevenseg decoder.
//  - Drives the active-low anode enables directly to the board.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  input clock frequency
//  REFRESH_HZ   1000         full-frame refresh rate (all digits once)
//  NUM_DIGITS   8            digits scanned, 2..8
//  GUARD_CYC    16           anti-ghost blanking cycles at start of each slot
// PORTS
//  clk          in   1               system clock
//  rst_n        in   1               asynchronous active-low reset
//  value_in     in   4*NUM_DIGITS    digit codes, digit 0 = bits [3:0] (rightmost)
//  dp_in        in   NUM_DIGITS      decimal point request per digit, 1 = lit
//  blank_in     in   NUM_DIGITS      1 = digit forced dark
//  load_in      in   1               capture value_in/dp_in/blank_in into pending buffer
//  bcd_out      out  4               code of current digit, to decoder bcd_in
//  dp_out       out  1               active-low dp, to decoder dp_in
//  an_out       out  NUM_DIGITS      active-low anode enables, one-hot-low or all-1
//  frame_start  out  1               1-cycle pulse when slot of digit 0 begins
// BEHAVIOUR
//  - Reset: clk and rst_n as above; reset asynchronous active-low, fully async assert, sync release.
//  - Reset values:
//    - an_out = all 1s; bcd_out = 0; dp_out = 1; frame_start = 0.
//    - Slot counter, digit index, and pending/active buffers all cleared to 0.
//  - Slot timing:
//    - DIG_CYC = CLK_FREQ_HZ/(REFRESH_HZ*NUM_DIGITS), integer division.
//    - Elaboration $error if DIG_CYC < GUARD_CYC+2.
//  - Slot counter runs 0..DIG_CYC-1. At wrap, digit index increments mod NUM_DIGITS (0,1,..,N-1,0).
//  - Per-slot phases, index k:
//    - GUARD phase, cnt < GUARD_CYC: an_out all 1s.
//    - ON phase, cnt >= GUARD_CYC: an_out[k] = 0 unless digit k is blanked.
//  - Decoder inputs: bcd_out/dp_out update on the first GUARD cycle of the slot and hold for the whole slot.
//    - Segments never change while an anode is on.
//  - All outputs registered: one clock after the internal counter/index change.
//  - Double buffer:
//    - load_in=1 writes the pending buffer every cycle it is high; last write wins.
//    - Pending is copied to active on the cycle the index wraps N-1 -> 0 (frame boundary).
//    - Load coinciding with the frame boundary: the new value_in bypasses directly into active.
//    - A frame never displays a mix of old and new values.
//  - frame_start asserts the cycle bcd_out first presents digit 0. First pulse comes DIG_CYC*NUM_DIGITS cycles after reset release.
//  - Blanked digit: anode stays 1 for the full slot; bcd_out/dp_out still driven (don't-care visually).
//  - dp_out = ~dp_active[k].
//  - Reset mid-frame: immediate return to reset values. Pending data is lost.
// CONFIGURATION
//  - Macro: SEVENSEG_LEADING_ZERO_BLANK_EN
//  - Defined: digits from NUM_DIGITS-1 downward are auto-blanked while code==0 and dp==0.
//    - The first non-zero or dp digit stops suppression.
//    - Digit 0 is never auto-blanked.
//    - Evaluated on the active buffer. Auto-blank ORs with blank_in.
//  - Undefined: only blank_in blanks; zeros display as '0'.
// STRUCTURE
//  - Package sevenseg_pkg:
//    - typedef logic [3:0] digit_t.
//    - localparam MAX_DIGITS = 8.
//    - function calc_dig_cyc(clk_hz, refresh_hz, ndig).
//  - Sub-module sevenseg_slot_timer: slot counter + digit index + wrap/frame strobes.
//  - Top holds buffers, blank logic, output registers.
// TESTING
//  - Bench params: CLK_FREQ_HZ=800, REFRESH_HZ=10, NUM_DIGITS=4, GUARD_CYC=2, giving DIG_CYC=20.
//  - Reset: hold rst_n=0 -> an_out=4'hF, dp_out=1, bcd_out=0. Release -> first frame_start after 80 cycles.
//  - Scan order: load value_in=16'h4321, dp_in=0 -> next frame shows:
//    - bcd_out 1,2,3,4 with an_out 1110,1101,1011,0111.
//    - Each anode low exactly 18 cycles, all-1 for 2 cycles between slots.
//  - Double buffer: load 16'hABCD mid-frame while showing 16'h4321 -> remaining digits stay 3,4; next frame shows D,C,B,A.
//    - Load on the boundary cycle -> that frame already shows the new value.
//  - Blank/dp: blank_in=4'b0100, dp_in=4'b0010 -> digit 2 anode never low; dp_out=0 only during digit 1 slot.
//  - Leading-zero (macro on): value 16'h0005 -> only digit 0 lit.
//    - Value 16'h0000 -> digit 0 shows '0'.
//    - Value 16'h0005 with dp_in=4'b0100 -> digits 0..2 lit.
//    - Macro off: all four lit.
//  - Reset mid-frame during an ON phase -> an_out=4'hF in the same cycle (async). Prior load is lost; frame shows 0000.

Source files
------------

// File: rtl/sevenseg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_pkg
//  Description : Shared types and slot-length helper for the 7-segment scanner.
//  Revision    : 1.0  initial release
// ============================================================================
package sevenseg_pkg;

    typedef logic [3:0] digit_t;

    localparam int MAX_DIGITS = 8;

    function automatic int calc_dig_cyc(input int clk_hz, input int refresh_hz, input int ndig);
        return clk_hz / (refresh_hz * ndig);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_scan_ctrl_if
//  Description : Host data/load inputs and display-side outputs of the scanner.
//  Revision    : 1.0  initial release
// ============================================================================
interface sevenseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    import sevenseg_pkg::*;

    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    load_in;
    digit_t                  bcd_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_start;

    modport master (
        output value_in, dp_in, blank_in, load_in,
        input  bcd_out, dp_out, an_out, frame_start
    );

    modport slave (
        input  value_in, dp_in, blank_in, load_in,
        output bcd_out, dp_out, an_out, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl_slot_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_slot_timer
//  Description : Slot counter and digit index with slot/frame phase strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module sevenseg_slot_timer #(
    parameter  int DIG_CYC    = 20,
    parameter  int NUM_DIGITS = 8,
    parameter  int GUARD_CYC  = 16,
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_slot_first,
    output logic                  o_on_phase,
    output logic                  o_frame_wrap,
    output logic                  o_frame_begin
);

    localparam int                 c_CNT_W    = (DIG_CYC > 1) ? $clog2(DIG_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIG_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD    = c_CNT_W'(GUARD_CYC);
    localparam logic [IDX_W-1:0]   c_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_frame_begin;
    logic               w_slot_wrap;

    assign w_slot_wrap   = (r_cnt == c_CNT_LAST);
    assign o_frame_wrap  = w_slot_wrap && (r_idx == c_IDX_LAST);
    assign o_idx         = r_idx;
    assign o_slot_first  = (r_cnt == '0);
    assign o_on_phase    = (r_cnt >= c_GUARD);
    // Only true after a real wrap, so the post-reset slot 0 does not pulse.
    assign o_frame_begin = r_frame_begin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_frame_begin <= 1'b0;
        end else begin
            r_frame_begin <= o_frame_wrap;
            if (w_slot_wrap) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_scan_ctrl
//  Description : Double-buffered, time-multiplexed common-anode digit scanner.
//                Optional macro SEVENSEG_LEADING_ZERO_BLANK_EN enables
//                automatic leading-zero suppression.
//  Revision    : 1.0  initial release
// ============================================================================
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int REFRESH_HZ  = 1000,
    parameter int NUM_DIGITS  = 8,
    parameter int GUARD_CYC   = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    sevenseg_scan_ctrl_if.slave bus
);

    localparam int                    c_DIG_CYC = calc_dig_cyc(CLK_FREQ_HZ, REFRESH_HZ, NUM_DIGITS);
    localparam int                    c_IDX_W   = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] c_AN_ONE  = NUM_DIGITS'(1);

    generate
        if (c_DIG_CYC < GUARD_CYC + 2) begin : g_bad_timing
            $error("sevenseg_scan_ctrl: slot length %0d too short for guard %0d", c_DIG_CYC, GUARD_CYC);
        end
        if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
            $error("sevenseg_scan_ctrl: NUM_DIGITS %0d out of range", NUM_DIGITS);
        end
    endgenerate

    logic [c_IDX_W-1:0]      w_idx;
    logic                    w_slot_first;
    logic                    w_on_phase;
    logic                    w_frame_wrap;
    logic                    w_frame_begin;

    logic [4*NUM_DIGITS-1:0] r_val_pend, r_val_act;
    logic [NUM_DIGITS-1:0]   r_dp_pend, r_dp_act;
    logic [NUM_DIGITS-1:0]   r_blank_pend, r_blank_act;
    logic [NUM_DIGITS-1:0]   w_auto_blank;
    logic [NUM_DIGITS-1:0]   w_blank_eff;

    digit_t                  r_bcd;
    logic                    r_dp_n;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_start;

    sevenseg_slot_timer #(
        .DIG_CYC    (c_DIG_CYC),
        .NUM_DIGITS (NUM_DIGITS),
        .GUARD_CYC  (GUARD_CYC)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_idx         (w_idx),
        .o_slot_first  (w_slot_first),
        .o_on_phase    (w_on_phase),
        .o_frame_wrap  (w_frame_wrap),
        .o_frame_begin (w_frame_begin)
    );

    // A load on the wrap cycle goes straight to active so that frame shows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val_pend   <= '0;
            r_dp_pend    <= '0;
            r_blank_pend <= '0;
            r_val_act    <= '0;
            r_dp_act     <= '0;
            r_blank_act  <= '0;
        end else begin
            if (bus.load_in) begin
                r_val_pend   <= bus.value_in;
                r_dp_pend    <= bus.dp_in;
                r_blank_pend <= bus.blank_in;
            end
            if (w_frame_wrap) begin
                r_val_act   <= bus.load_in ? bus.value_in : r_val_pend;
                r_dp_act    <= bus.load_in ? bus.dp_in    : r_dp_pend;
                r_blank_act <= bus.load_in ? bus.blank_in : r_blank_pend;
            end
        end
    end

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    logic w_lz_run;

    always_comb begin
        w_auto_blank = '0;
        w_lz_run     = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (w_lz_run && (r_val_act[4*i +: 4] == 4'h0) && !r_dp_act[i]) begin
                w_auto_blank[i] = 1'b1;
            end else begin
                w_lz_run = 1'b0;
            end
        end
    end
`else
    assign w_auto_blank = '0;
`endif

    assign w_blank_eff = r_blank_act | w_auto_blank;

    // Segments latch only at slot start, while the anodes are still in guard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd         <= '0;
            r_dp_n        <= 1'b1;
            r_an          <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_begin;
            if (w_slot_first) begin
                r_bcd  <= r_val_act[{w_idx, 2'b00} +: 4];
                r_dp_n <= ~r_dp_act[w_idx];
            end
            if (w_on_phase && !w_blank_eff[w_idx]) begin
                r_an <= ~(c_AN_ONE << w_idx);
            end else begin
                r_an <= '1;
            end
        end
    end

    assign bus.bcd_out     = r_bcd;
    assign bus.dp_out      = r_dp_n;
    assign bus.an_out      = r_an;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sevenseg_scan_ctrl
//  Description : Self-checking bench: directed frame table, buffer corner
//                cases, async reset and randomized loads against a model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sevenseg_scan_ctrl;

    localparam int ND    = 4;
    localparam int SLOT  = 20;   // 800 / (10 * 4)
    localparam int GUARD = 2;
    localparam int FRAME = SLOT * ND;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } rec_t;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [15:0] exp_bcd;   // nibble k = code shown in slot k
        logic [15:0] exp_an;    // nibble k = an_out mid-ON of slot k
        logic [3:0]  exp_dpo;   // bit k = dp_out during slot k
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   t;
    int   vectors;
    int   miscompares;
    int   low_cnt [ND];
    int   dark_cnt;
    rec_t m_pend;
    rec_t m_frames [$];
    vec_t tbl [8];

    always #5 clk = ~clk;

    sevenseg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    sevenseg_scan_ctrl #(
        .CLK_FREQ_HZ (800),
        .REFRESH_HZ  (10),
        .NUM_DIGITS  (ND),
        .GUARD_CYC   (GUARD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Digits that are dark for a given frame's data.
    function automatic logic [3:0] eff_blank(input rec_t d);
        logic [3:0] b;
        int         top;
        b   = d.blank;
        top = 0;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        for (int i = 0; i < ND; i++)
            if (d.val[4*i +: 4] != 4'h0 || d.dp[i]) top = i;
        for (int i = 1; i < ND; i++)
            if (i > top) b[i] = 1'b1;
`endif
        return b;
    endfunction

    task automatic expect_val(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    // Outputs at time t reflect scan step t-1 (one register stage).
    task automatic check_cycle();
        int         s, f, k, c;
        rec_t       d;
        logic [3:0] e_an, e_bcd, b;
        logic       e_dp, e_fs;
        e_an = 4'hF; e_bcd = 4'h0; e_dp = 1'b1; e_fs = 1'b0;
        if (t > 0) begin
            s = t - 1;
            f = s / FRAME;
            k = (s % FRAME) / SLOT;
            c = s % SLOT;
            if (f < m_frames.size()) d = m_frames[f];
            else d = '0;
            b     = eff_blank(d);
            e_bcd = d.val[4*k +: 4];
            e_dp  = ~d.dp[k];
            e_an  = (c >= GUARD && !b[k]) ? ~(4'b0001 << k) : 4'hF;
            e_fs  = (s % FRAME == 0) && (s > 0);
        end
        for (int i = 0; i < ND; i++)
            if (bus.an_out[i] === 1'b0) low_cnt[i]++;
        if (bus.an_out === 4'hF) dark_cnt++;
        vectors++;
        if ({bus.an_out, bus.bcd_out, bus.dp_out, bus.frame_start} !== {e_an, e_bcd, e_dp, e_fs}) begin
            miscompares++;
            $display("FAIL scan t=%0d: got an=%h bcd=%h dp=%b fs=%b, expected an=%h bcd=%h dp=%b fs=%b",
                     t, bus.an_out, bus.bcd_out, bus.dp_out, bus.frame_start, e_an, e_bcd, e_dp, e_fs);
        end
    endtask

    task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        check_cycle();
        bus.load_in  = ld;
        bus.value_in = v;
        bus.dp_in    = dp;
        bus.blank_in = bl;
        if (ld) m_pend = '{val: v, dp: dp, blank: bl};
        if (t % FRAME == FRAME - 1) m_frames.push_back(m_pend);
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    task automatic cycle_idle();
        cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic run_to(input int target);
        while (t < target) cycle_idle();
    endtask

    task automatic model_reset();
        t = 0;
        m_frames.delete();
        m_frames.push_back('0);
        m_pend = '0;
    endtask

    int L, f, tt;

    initial begin
        vectors = 0; miscompares = 0; dark_cnt = 0;
        foreach (low_cnt[i]) low_cnt[i] = 0;
        rst_n = 1'b0;
        bus.load_in = 1'b0; bus.value_in = '0; bus.dp_in = '0; bus.blank_in = '0;
        model_reset();

        //            val      dp     blank  exp_bcd  exp_an   exp_dpo
        tbl[0] = '{16'h4321, 4'h0, 4'h0, 16'h4321, 16'h7BDE, 4'hF};
        tbl[1] = '{16'h4321, 4'h2, 4'h4, 16'h4321, 16'h7FDE, 4'hD};
        tbl[5] = '{16'h1020, 4'h0, 4'h0, 16'h1020, 16'h7BDE, 4'hF};
        tbl[6] = '{16'hABCD, 4'h0, 4'h9, 16'hABCD, 16'hFBDF, 4'hF};
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        tbl[2] = '{16'h0005, 4'h0, 4'h0, 16'h0005, 16'hFFFE, 4'hF};
        tbl[3] = '{16'h0000, 4'h0, 4'h0, 16'h0000, 16'hFFFE, 4'hF};
        tbl[4] = '{16'h0005, 4'h4, 4'h0, 16'h0005, 16'hFBDE, 4'hB};
        tbl[7] = '{16'h0300, 4'h0, 4'h0, 16'h0300, 16'hFBDE, 4'hF};
`else
        tbl[2] = '{16'h0005, 4'h0, 4'h0, 16'h0005, 16'h7BDE, 4'hF};
        tbl[3] = '{16'h0000, 4'h0, 4'h0, 16'h0000, 16'h7BDE, 4'hF};
        tbl[4] = '{16'h0005, 4'h4, 4'h0, 16'h0005, 16'h7BDE, 4'hB};
        tbl[7] = '{16'h0300, 4'h0, 4'h0, 16'h0300, 16'h7BDE, 4'hF};
`endif

        // Reset values while held
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_val("rst_an", bus.an_out, 4'hF);
        expect_val("rst_bcd", bus.bcd_out, 4'h0);
        expect_val("rst_dp", {3'b000, bus.dp_out}, 4'h1);
        expect_val("rst_fs", {3'b000, bus.frame_start}, 4'h0);
        rst_n = 1'b1;
        model_reset();

        // First frame_start: one full frame plus the output register stage
        while (bus.frame_start !== 1'b1 && t < 200) cycle_idle();
        vectors++;
        if (t != FRAME + 1) begin
            miscompares++;
            $display("FAIL first_frame_start: seen at edge %0d expected %0d", t, FRAME + 1);
        end

        // Directed frame table
        for (int i = 0; i < 8; i++) begin
            L = t;
            cycle(1'b1, tbl[i].val, tbl[i].dp, tbl[i].blank);
            f = L / FRAME + 1;
            for (int k = 0; k < ND; k++) begin
                run_to(f * FRAME + 1 + k * SLOT + 10);
                expect_val($sformatf("tbl%0d_bcd%0d", i, k), bus.bcd_out, tbl[i].exp_bcd[4*k +: 4]);
                expect_val($sformatf("tbl%0d_an%0d", i, k), bus.an_out, tbl[i].exp_an[4*k +: 4]);
                expect_val($sformatf("tbl%0d_dp%0d", i, k), {3'b000, bus.dp_out}, {3'b000, tbl[i].exp_dpo[k]});
            end
        end

        // Mid-frame load: rest of frame keeps old value, next frame is new
        L = t;
        cycle(1'b1, 16'h4321, 4'h0, 4'h0);
        f = L / FRAME + 1;
        run_to(f * FRAME + 1 + SLOT + 5);
        cycle(1'b1, 16'hABCD, 4'h0, 4'h0);
        run_to(f * FRAME + 1 + 2 * SLOT + 10);
        expect_val("dbuf_old_d2", bus.bcd_out, 4'h3);
        run_to(f * FRAME + 1 + 3 * SLOT + 10);
        expect_val("dbuf_old_d3", bus.bcd_out, 4'h4);
        run_to((f + 1) * FRAME + 1);
        foreach (low_cnt[i]) low_cnt[i] = 0;
        dark_cnt = 0;
        for (int k = 0; k < ND; k++) begin
            run_to((f + 1) * FRAME + 1 + k * SLOT + 10);
            expect_val($sformatf("dbuf_new_d%0d", k), bus.bcd_out, 4'(16'hABCD >> (4 * k)));
        end
        run_to((f + 1) * FRAME + 1 + FRAME);
        for (int k = 0; k < ND; k++) begin
            vectors++;
            if (low_cnt[k] != SLOT - GUARD) begin
                miscompares++;
                $display("FAIL anode_on_len d%0d: got %0d cycles expected %0d", k, low_cnt[k], SLOT - GUARD);
            end
        end
        vectors++;
        if (dark_cnt != ND * GUARD) begin
            miscompares++;
            $display("FAIL guard_len: got %0d dark cycles expected %0d", dark_cnt, ND * GUARD);
        end

        // Load exactly on the frame-boundary cycle bypasses into that frame
        tt = t - (t % FRAME) + FRAME - 1;
        run_to(tt);
        L = t;
        cycle(1'b1, 16'h5A5A, 4'h0, 4'h0);
        f = L / FRAME + 1;
        run_to(f * FRAME + 1 + 10);
        expect_val("boundary_d0", bus.bcd_out, 4'hA);
        run_to(f * FRAME + 1 + SLOT + 10);
        expect_val("boundary_d1", bus.bcd_out, 4'h5);

        // Async reset during an ON phase; pending load is discarded
        cycle(1'b1, 16'h9876, 4'hF, 4'h0);
        run_to(t + 3);
        #2 rst_n = 1'b0;
        #1;
        expect_val("async_rst_an", bus.an_out, 4'hF);
        expect_val("async_rst_bcd", bus.bcd_out, 4'h0);
        expect_val("async_rst_dp", {3'b000, bus.dp_out}, 4'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < ND; k++) begin
            run_to(FRAME + 1 + k * SLOT + 10);
            expect_val($sformatf("post_rst_d%0d", k), bus.bcd_out, 4'h0);
            expect_val($sformatf("post_rst_dp%0d", k), {3'b000, bus.dp_out}, 4'h1);
        end

        // Randomized loads, including loads on boundary cycles
        repeat (1600) begin
            logic ld;
            ld = ($urandom_range(0, 24) == 0) ||
                 ((t % FRAME == FRAME - 1) && ($urandom_range(0, 2) == 0));
            cycle(ld, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
